// File: rtl/test_arith_int_if.sv
// Host-side bundle for the arithmetic self-test engine: ic/lc access plus the
// test_req / test_busy / test_return method-call handshake.
interface test_arith_int_if;
  logic [31:0] ic_in;
  logic        ic_we;
  logic [31:0] ic_out;
  logic [63:0] lc_in;
  logic        lc_we;
  logic [63:0] lc_out;
  logic        test_req;
  logic        test_busy;
  logic        test_return;

  modport slave (
    input  ic_in, ic_we, lc_in, lc_we, test_req,
    output ic_out, lc_out, test_busy, test_return
  );

  modport master (
    output ic_in, ic_we, lc_in, lc_we, test_req,
    input  ic_out, lc_out, test_busy, test_return
  );
endinterface

// File: rtl/test_arith_int.sv
// Integer-arithmetic self-test: a fixed ten-step chain of Java-semantics
// 32/64-bit operations, each checked against a constant into a sticky fail flag.
module test_arith_int (
  input  logic               clk,
  input  logic               reset,
  test_arith_int_if.slave    bus
);

  typedef enum logic [3:0] {
    IDLE, S1, S2, S3, S4, S5, S6, S7, S8, S9, S10, DONE
  } state_t;

  localparam logic signed [63:0] LC_MULT = -64'sd1000000000;
  localparam logic signed [63:0] LC_EXP  = -64'sd39000000000;

  state_t             r_state;
  state_t             w_stateNext;
  logic signed [31:0] r_ic;
  logic signed [63:0] r_lc;
  logic               r_busy;
  logic               r_ret;
  logic               r_fail;

  logic signed [31:0] w_icRes;
  logic signed [31:0] w_icExp;
  logic signed [63:0] w_icExt;
  logic signed [63:0] w_lcRes;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    unique case (r_state)
      IDLE:    if (bus.test_req) w_stateNext = S1;
      S1:      w_stateNext = S2;
      S2:      w_stateNext = S3;
      S3:      w_stateNext = S4;
      S4:      w_stateNext = S5;
      S5:      w_stateNext = S6;
      S6:      w_stateNext = S7;
      S7:      w_stateNext = S8;
      S8:      w_stateNext = S9;
      S9:      w_stateNext = S10;
      S10:     w_stateNext = DONE;
      DONE:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Divisors are constant, so / and % reduce to shift/adjust logic while keeping
  // SV's truncate-toward-zero semantics, which match Java.
  always_comb begin
    w_icRes = r_ic;
    w_icExp = r_ic;
    unique case (r_state)
      S1: begin w_icRes = 32'sd3 + 32'sd4;             w_icExp = 32'sd7;   end
      S2: begin w_icRes = r_ic - 32'sd10;              w_icExp = -32'sd3;  end
      S3: begin w_icRes = r_ic * 32'sd5;               w_icExp = -32'sd15; end
      S4: begin w_icRes = r_ic / 32'sd4;               w_icExp = -32'sd3;  end
      S5: begin w_icRes = r_ic % 32'sd2;               w_icExp = -32'sd1;  end
      S6: begin w_icRes = r_ic << 5'd4;                w_icExp = -32'sd16; end
      S7: begin w_icRes = r_ic >>> 5'd2;               w_icExp = -32'sd4;  end
      S8: begin w_icRes = r_ic >> 5'd28;               w_icExp = 32'sd15;  end
      S9: begin w_icRes = (r_ic & 32'sd6) ^ 32'sh21;   w_icExp = 32'sd39;  end
      default: ;
    endcase
  end

  assign w_icExt = {{32{r_ic[31]}}, r_ic};
  assign w_lcRes = w_icExt * LC_MULT;

  // Host writes land only in IDLE; during a run the step results own ic/lc.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ic   <= '0;
      r_lc   <= '0;
      r_busy <= 1'b0;
      r_ret  <= 1'b0;
      r_fail <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.ic_we) r_ic <= bus.ic_in;
          if (bus.lc_we) r_lc <= bus.lc_in;
          if (bus.test_req) begin
            r_fail <= 1'b0;
            r_busy <= 1'b1;
          end
        end
        S10: begin
          r_lc <= w_lcRes;
          if (w_lcRes != LC_EXP) r_fail <= 1'b1;
        end
        DONE: begin
          r_ret  <= ~r_fail;
          r_busy <= 1'b0;
        end
        default: begin
          r_ic <= w_icRes;
          if (w_icRes != w_icExp) r_fail <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ic_out      = r_ic;
  assign bus.lc_out      = r_lc;
  assign bus.test_busy   = r_busy;
  assign bus.test_return = r_ret;

endmodule

// File: tb/tb_test_arith_int.sv
// Directed bench for test_arith_int: reset values, host-write vectors each
// followed by a run, busy-write rejection, back-to-back runs and mid-run reset.
module tb_test_arith_int;

  localparam logic [63:0] LC_FINAL = -64'sd39000000000;

  logic clk;
  logic reset;
  int   passCount;
  int   checkCount;

  test_arith_int_if bus ();

  test_arith_int dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] icIn;
    bit          icWe;
    logic [63:0] lcIn;
    bit          lcWe;
    logic [31:0] icExp;
    logic [63:0] lcExp;
  } vec_t;

  vec_t vecs [5];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    bus.ic_in = v.icIn;
    bus.ic_we = v.icWe;
    bus.lc_in = v.lcIn;
    bus.lc_we = v.lcWe;
    @(negedge clk);
    bus.ic_we = 1'b0;
    bus.lc_we = 1'b0;
  endtask

  // Start a run and wait for it to end; optionally keep test_req high or
  // attempt host writes while busy.
  task automatic runTest(input bit holdReq, input bit pulseBusy);
    int n;
    @(negedge clk);
    bus.test_req = 1'b1;
    n = 0;
    while (!bus.test_busy && n < 2) begin
      @(negedge clk);
      n++;
    end
    checkOutput("busyRise", 64'(bus.test_busy), 64'd1);
    if (!holdReq) bus.test_req = 1'b0;
    if (pulseBusy) begin
      @(negedge clk);
      @(negedge clk);
      bus.ic_in = 32'd99;
      bus.ic_we = 1'b1;
      bus.lc_in = 64'd77;
      bus.lc_we = 1'b1;
      @(negedge clk);
      bus.ic_we = 1'b0;
      bus.lc_we = 1'b0;
    end
    n = 0;
    while (bus.test_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("busyFall", 64'(bus.test_busy), 64'd0);
    checkOutput("testReturn", 64'(bus.test_return), 64'd1);
    checkOutput("icFinal", 64'(bus.ic_out), 64'd39);
    checkOutput("lcFinal", bus.lc_out, LC_FINAL);
  endtask

  initial begin
    int n;
    passCount  = 0;
    checkCount = 0;

    vecs[0] = '{32'h0000_1234, 1'b1, 64'd5,                 1'b1, 32'h0000_1234, 64'd5};
    vecs[1] = '{32'hDEAD_BEEF, 1'b1, 64'd123,               1'b0, 32'hDEAD_BEEF, LC_FINAL};
    vecs[2] = '{32'd7,         1'b0, 64'h8000_0000_0000_0000, 1'b1, 32'd39,      64'h8000_0000_0000_0000};
    vecs[3] = '{32'd1,         1'b0, 64'd2,                 1'b0, 32'd39,        LC_FINAL};
    vecs[4] = '{32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};

    reset        = 1'b0;
    bus.ic_in    = '0;
    bus.ic_we    = 1'b0;
    bus.lc_in    = '0;
    bus.lc_we    = 1'b0;
    bus.test_req = 1'b0;

    repeat (6) @(negedge clk);
    checkOutput("rstIc", 64'(bus.ic_out), 64'd0);
    checkOutput("rstLc", bus.lc_out, 64'd0);
    checkOutput("rstBusy", 64'(bus.test_busy), 64'd0);
    checkOutput("rstReturn", 64'(bus.test_return), 64'd0);
    reset = 1'b1;

    $display("[TB] first run after reset");
    runTest(1'b0, 1'b0);

    $display("[TB] host-write vectors");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d_ic", i), 64'(bus.ic_out), 64'(vecs[i].icExp));
      checkOutput($sformatf("vec%0d_lc", i), bus.lc_out, vecs[i].lcExp);
      runTest(1'b0, 1'b0);
    end

    $display("[TB] writes while busy");
    runTest(1'b0, 1'b1);

    $display("[TB] back-to-back runs");
    runTest(1'b1, 1'b0);
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      checkOutput($sformatf("rerunBusy%0d", r), 64'(bus.test_busy), 64'd1);
      checkOutput($sformatf("rerunHoldReturn%0d", r), 64'(bus.test_return), 64'd1);
      n = 0;
      while (bus.test_busy && n < 200) begin
        @(negedge clk);
        n++;
      end
      checkOutput($sformatf("rerunFall%0d", r), 64'(bus.test_busy), 64'd0);
      checkOutput($sformatf("rerunReturn%0d", r), 64'(bus.test_return), 64'd1);
      checkOutput($sformatf("rerunIc%0d", r), 64'(bus.ic_out), 64'd39);
    end
    bus.test_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("idleAfterReq", 64'(bus.test_busy), 64'd0);

    $display("[TB] reset mid-run");
    @(negedge clk);
    bus.test_req = 1'b1;
    n = 0;
    while (!bus.test_busy && n < 2) begin
      @(negedge clk);
      n++;
    end
    bus.test_req = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midRunIc", 64'(bus.ic_out), 64'hFFFF_FFF1);
    #2 reset = 1'b0;
    #1;
    checkOutput("abortIc", 64'(bus.ic_out), 64'd0);
    checkOutput("abortLc", bus.lc_out, 64'd0);
    checkOutput("abortBusy", 64'(bus.test_busy), 64'd0);
    checkOutput("abortReturn", 64'(bus.test_return), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    runTest(1'b0, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
